fcw_sweep_gen: RTL and testbench

Frequency-sweep controller that sits directly upstream of the NCO and drives its phase-increment (FCW) input. It steps the FCW from a start value to a stop value in fixed increments, holding each value for a programmable dwell. Sweeps run single-shot or continuously, giving chirp/sweep stimulus on the DA output without software involvement. It runs in the 100 MHz NCO clock domain.

---
 rtl/fcw_sweep_gen_if.sv | 31 +++
 rtl/fcw_sweep_gen.sv | 126 ++++++++++++
 tb/tb_fcw_sweep_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcw_sweep_gen_if.sv
// Config/control and FCW output bundle between a sweep master and fcw_sweep_gen.
interface fcw_sweep_gen_if #(
  parameter int FCW_W   = 16,
  parameter int DWELL_W = 16
);
  logic [FCW_W-1:0]   cfg_start_fcw;
  logic [FCW_W-1:0]   cfg_stop_fcw;
  logic [FCW_W-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_load;
  logic               continuous;
  logic               start;
  logic               abort;
  logic [FCW_W-1:0]   fcw_out;
  logic               fcw_valid;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
    output cfg_start_fcw, cfg_stop_fcw, cfg_step, cfg_dwell, cfg_load,
           continuous, start, abort,
    input  fcw_out, fcw_valid, busy, done, wrap
  );

  modport slave (
    input  cfg_start_fcw, cfg_stop_fcw, cfg_step, cfg_dwell, cfg_load,
           continuous, start, abort,
    output fcw_out, fcw_valid, busy, done, wrap
  );
endinterface

// File: rtl/fcw_sweep_gen.sv
// Frequency-sweep controller feeding the NCO FCW: start..stop in fixed steps with dwell.
// Define FCW_SWEEP_TRIANGLE_EN to step back down to start after the top point.
module fcw_sweep_gen #(
  parameter int FCW_W   = 16,
  parameter int DWELL_W = 16
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  fcw_sweep_gen_if.slave bus
);
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state_q;
  logic [FCW_W-1:0]   start_q, stop_q, step_q, fcw_q;
  logic [DWELL_W-1:0] dwell_q, cnt_q;
  logic               vld_q, busy_q, done_q, wrap_q;
  logic [FCW_W:0]     up_sum;
  logic               up_ok, expire;

  // Extra bit catches carry so the FCW never wraps past full scale.
  assign up_sum = {1'b0, fcw_q} + {1'b0, step_q};
  assign up_ok  = (step_q != '0) && !up_sum[FCW_W] && (up_sum[FCW_W-1:0] <= stop_q);
  assign expire = (cnt_q == dwell_q);

`ifdef FCW_SWEEP_TRIANGLE_EN
  logic           dir_q;
  logic [FCW_W:0] dn_dif;
  logic           dn_ok;

  assign dn_dif = {1'b0, fcw_q} - {1'b0, step_q};
  assign dn_ok  = (step_q != '0) && !dn_dif[FCW_W] && (dn_dif[FCW_W-1:0] >= start_q);
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      fcw_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef FCW_SWEEP_TRIANGLE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cfg_load) begin
            start_q <= bus.cfg_start_fcw;
            stop_q  <= bus.cfg_stop_fcw;
            step_q  <= bus.cfg_step;
            dwell_q <= bus.cfg_dwell;
          end
          if (bus.start && !bus.abort) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            fcw_q   <= start_q;
            vld_q   <= 1'b1;
            cnt_q   <= '0;
`ifdef FCW_SWEEP_TRIANGLE_EN
            dir_q   <= 1'b0;
`endif
          end
        end
        SWEEP: begin
          // abort outranks dwell expiry: no done/wrap, FCW frozen
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!expire) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
`ifdef FCW_SWEEP_TRIANGLE_EN
            if (!dir_q && up_ok) begin
              fcw_q <= up_sum[FCW_W-1:0];
              vld_q <= 1'b1;
            end else if (dn_ok) begin
              dir_q <= 1'b1;
              fcw_q <= dn_dif[FCW_W-1:0];
              vld_q <= 1'b1;
            end else if (bus.continuous) begin
              dir_q  <= 1'b0;
              fcw_q  <= start_q;
              vld_q  <= 1'b1;
              wrap_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
`else
            if (up_ok) begin
              fcw_q <= up_sum[FCW_W-1:0];
              vld_q <= 1'b1;
            end else if (bus.continuous) begin
              fcw_q  <= start_q;
              vld_q  <= 1'b1;
              wrap_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fcw_out   = fcw_q;
  assign bus.fcw_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_fcw_sweep_gen.sv
// Randomized and directed bench for fcw_sweep_gen against a point-list sweep model.
module tb_fcw_sweep_gen;
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs;

  fcw_sweep_gen_if #(.FCW_W(16), .DWELL_W(16)) bus ();
  fcw_sweep_gen #(.FCW_W(16), .DWELL_W(16)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // {fcw_out, fcw_valid, busy, done, wrap}
  assign obs = {bus.fcw_out, bus.fcw_valid, bus.busy, bus.done, bus.wrap};

  // Expected outputs for cycles 1..n after the start sample, built from the list of sweep points.
  function automatic void build_trace(int st, int sp, int stp, int dw, bit cont, int n);
    int pts[$];
    int v;
    int rep;
    exp_q.delete();
    pts.push_back(st);
    v = st;
    if (stp != 0) begin
      while (v + stp <= sp && v + stp <= 65535) begin
        v += stp;
        pts.push_back(v);
      end
`ifdef FCW_SWEEP_TRIANGLE_EN
      while (v - stp >= st) begin
        v -= stp;
        pts.push_back(v);
      end
`endif
    end
    rep = 0;
    while (exp_q.size() < n) begin
      foreach (pts[p])
        for (int h = 0; h <= dw; h++)
          exp_q.push_back({16'(pts[p]), (h == 0), 1'b1, 1'b0, (h == 0 && p == 0 && rep > 0)});
      if (!cont) begin
        exp_q.push_back({16'(v), 4'b0010});
        while (exp_q.size() < n) exp_q.push_back({16'(v), 4'b0000});
      end
      rep++;
    end
  endfunction

  task automatic load_cfg(int st, int sp, int stp, int dw);
    @(negedge sys_clk);
    bus.cfg_start_fcw = 16'(st);
    bus.cfg_stop_fcw  = 16'(sp);
    bus.cfg_step      = 16'(stp);
    bus.cfg_dwell     = 16'(dw);
    bus.cfg_load      = 1'b1;
    @(negedge sys_clk);
    bus.cfg_load      = 1'b0;
  endtask

  task automatic stop_sweep();
    @(negedge sys_clk);
    bus.abort = 1'b1;
    @(negedge sys_clk);
    bus.abort      = 1'b0;
    bus.continuous = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    bus.cfg_start_fcw = '0; bus.cfg_stop_fcw = '0; bus.cfg_step = '0; bus.cfg_dwell = '0;
    bus.cfg_load = 1'b0; bus.continuous = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_cnt++;
    if (obs !== 20'h0) $display("FAIL reset_outputs got %h want %h", obs, 20'h0);
    else pass_cnt++;
    sys_rst = 1'b0;
    // zeroed shadows: one point at 0, then done
    build_trace(0, 0, 0, 0, 0, 4);
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk); bus.start = 1'b0;
      chk_cnt++;
      if (obs !== exp_q[i]) $display("FAIL reset_shadow c%0d got %h want %h", i + 1, obs, exp_q[i]);
      else pass_cnt++;
    end
    load_cfg(655, 6553, 655, 3);
    bus.start = 1'b1;
    repeat (6) begin @(negedge sys_clk); bus.start = 1'b0; end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk_cnt++;
    if (obs !== 20'h0) $display("FAIL reset_midsweep got %h want %h", obs, 20'h0);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int nv = 0;
    load_cfg(655, 6553, 655, 3);
    build_trace(655, 6553, 655, 3, 0, 46);
    bus.start = 1'b1;
    for (int i = 0; i < 46; i++) begin
      @(negedge sys_clk); bus.start = 1'b0;
      if (bus.fcw_valid) nv++;
      chk_cnt++;
      if (obs !== exp_q[i]) $display("FAIL basic c%0d got %h want %h", i + 1, obs, exp_q[i]);
      else pass_cnt++;
    end
`ifndef FCW_SWEEP_TRIANGLE_EN
    chk_cnt++;
    if (nv !== 10) $display("FAIL basic_valid_count got %0d want 10", nv);
    else pass_cnt++;
`endif
  endtask

  task automatic test_overflow();
    load_cfg(65000, 65535, 600, 0);
    build_trace(65000, 65535, 600, 0, 0, 5);
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk); bus.start = 1'b0;
      chk_cnt++;
      if (obs !== exp_q[i]) $display("FAIL overflow c%0d got %h want %h", i + 1, obs, exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_continuous();
    load_cfg(100, 300, 100, 1);
    bus.continuous = 1'b1;
    build_trace(100, 300, 100, 1, 1, 30);
    bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk); bus.start = 1'b0;
      chk_cnt++;
      if (obs !== exp_q[i]) $display("FAIL continuous c%0d got %h want %h", i + 1, obs, exp_q[i]);
      else pass_cnt++;
    end
    stop_sweep();
    chk_cnt++;
    if (obs[2:0] !== 3'b000) $display("FAIL continuous_abort flags got %b want 000", obs[2:0]);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    load_cfg(655, 6553, 655, 3);
    build_trace(655, 6553, 655, 3, 0, 10);
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk); bus.start = 1'b0;
      chk_cnt++;
      if (obs !== exp_q[i]) $display("FAIL abort_pre c%0d got %h want %h", i + 1, obs, exp_q[i]);
      else pass_cnt++;
    end
    bus.abort = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk); bus.abort = 1'b0;
      chk_cnt++;
      if (obs !== {16'd1965, 4'b0000}) $display("FAIL abort_hold c%0d got %h want %h", i + 11, obs, {16'd1965, 4'b0000});
      else pass_cnt++;
    end
    bus.start = 1'b1; bus.abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk); bus.start = 1'b0; bus.abort = 1'b0;
      chk_cnt++;
      if (obs !== {16'd1965, 4'b0000}) $display("FAIL start_abort_idle c%0d got %h want %h", i, obs, {16'd1965, 4'b0000});
      else pass_cnt++;
    end
  endtask

  task automatic test_cfg_busy();
    load_cfg(655, 6553, 655, 3);
    bus.start = 1'b1;
    repeat (5) begin @(negedge sys_clk); bus.start = 1'b0; end
    bus.cfg_start_fcw = 16'd1000;
    bus.cfg_load      = 1'b1;
    @(negedge sys_clk);
    bus.cfg_load      = 1'b0;
    stop_sweep();
    build_trace(655, 6553, 655, 3, 0, 8);
    bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk); bus.start = 1'b0;
      chk_cnt++;
      if (obs !== exp_q[i]) $display("FAIL cfg_busy_ignored c%0d got %h want %h", i + 1, obs, exp_q[i]);
      else pass_cnt++;
    end
    stop_sweep();
    load_cfg(1000, 6553, 655, 3);
    build_trace(1000, 6553, 655, 3, 0, 6);
    bus.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk); bus.start = 1'b0;
      chk_cnt++;
      if (obs !== exp_q[i]) $display("FAIL cfg_idle_load c%0d got %h want %h", i + 1, obs, exp_q[i]);
      else pass_cnt++;
    end
    stop_sweep();
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int st, sp, stp, dw;
      bit cont;
      st   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) : 65535 - int'($urandom_range(0, 3000));
      sp   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) : 65535;
      stp  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 5000));
      dw   = int'($urandom_range(0, 4));
      cont = 1'($urandom_range(0, 1));
      load_cfg(st, sp, stp, dw);
      bus.continuous = cont;
      build_trace(st, sp, stp, dw, cont, 60);
      bus.start = 1'b1;
      for (int i = 0; i < 60; i++) begin
        @(negedge sys_clk); bus.start = 1'b0;
        chk_cnt++;
        if (obs !== exp_q[i])
          $display("FAIL random it%0d c%0d st=%0d sp=%0d stp=%0d dw=%0d cont=%0d got %h want %h",
                   it, i + 1, st, sp, stp, dw, cont, obs, exp_q[i]);
        else pass_cnt++;
      end
      stop_sweep();
    end
  endtask

`ifdef FCW_SWEEP_TRIANGLE_EN
  task automatic test_triangle();
    int nv = 0;
    load_cfg(100, 400, 100, 0);
    build_trace(100, 400, 100, 0, 0, 10);
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk); bus.start = 1'b0;
      if (bus.fcw_valid) nv++;
      chk_cnt++;
      if (obs !== exp_q[i]) $display("FAIL triangle c%0d got %h want %h", i + 1, obs, exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (nv !== 7) $display("FAIL triangle_valid_count got %0d want 7", nv);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_continuous();
    test_abort();
    test_cfg_busy();
    test_random();
`ifdef FCW_SWEEP_TRIANGLE_EN
    test_triangle();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
